rsa_uart_master: RTL and testbench

// Avalon-MM master that drives the RSA-256 core from a byte-serial UART (RS-232 Avalon slave).

---
 rtl/rsa_uart_master.sv | 91 +++++++++
 tb/tb_rsa_uart_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_uart_master.sv
// rsa_uart_master: polls a UART over Avalon-MM, loads N, D and ciphertext blocks into the RSA core,
// and streams the 31-byte plaintext of each block back out through the UART.
module rsa_uart_master #(
    parameter logic [4:0] RX_BASE     = 5'd0,
    parameter logic [4:0] TX_BASE     = 5'd4,
    parameter logic [4:0] STATUS_BASE = 5'd8,
    parameter int         RX_OK_BIT   = 7,
    parameter int         TX_OK_BIT   = 6,
    parameter int         IN_BYTES    = 32,
    parameter int         OUT_BYTES   = 31
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished
);
    localparam int CW = $clog2(IN_BYTES);
    typedef enum logic [2:0] {S_GET_STAT, S_GET_DATA, S_START, S_WAIT, S_PUT_STAT, S_PUT_DATA} state_t;
    typedef enum logic [1:0] {P_N, P_D, P_A} phase_t;
    state_t state, state_nxt;
    phase_t phase;
    logic [CW-1:0] byte_cnt;
    logic [255:0] n_r, d_r, a_r;
    logic [247:0] res_r;
    logic done, in_last, out_last, unused_ok;
    assign done = (avm_read || avm_write) && !avm_waitrequest;
    assign in_last = byte_cnt == CW'(IN_BYTES - 1);
    assign out_last = byte_cnt == CW'(OUT_BYTES - 1);
    assign o_core_n = n_r;
    assign o_core_d = d_r;
    assign o_core_a = a_r;
    assign unused_ok = ^{avm_readdata, i_core_result[255:248]};
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= S_GET_STAT;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            S_GET_STAT: if (done && avm_readdata[RX_OK_BIT]) state_nxt = S_GET_DATA;
            S_GET_DATA: if (done) state_nxt = (in_last && phase == P_A) ? S_START : S_GET_STAT;
            S_START:    state_nxt = S_WAIT;
            S_WAIT:     if (i_core_finished) state_nxt = S_PUT_STAT;
            S_PUT_STAT: if (done && avm_readdata[TX_OK_BIT]) state_nxt = S_PUT_DATA;
            S_PUT_DATA: if (done) state_nxt = out_last ? S_GET_STAT : S_PUT_STAT;
            default:    state_nxt = S_GET_STAT;
        endcase
    end
    // Requests are pure functions of state, so they cannot move while the slave stalls.
    always_comb begin
        avm_read = state inside {S_GET_STAT, S_GET_DATA, S_PUT_STAT};
        avm_write = state == S_PUT_DATA;
        avm_address = state == S_GET_DATA ? RX_BASE : state == S_PUT_DATA ? TX_BASE : STATUS_BASE;
        avm_writedata = state == S_PUT_DATA ? {24'd0, res_r[247:240]} : 32'd0;
        o_core_start = state == S_START;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase <= P_N;
            byte_cnt <= '0;
            n_r <= '0;
            d_r <= '0;
            a_r <= '0;
            res_r <= '0;
        end else if (state == S_GET_DATA && done) begin
            n_r <= phase == P_N ? {n_r[247:0], avm_readdata[7:0]} : n_r;
            d_r <= phase == P_D ? {d_r[247:0], avm_readdata[7:0]} : d_r;
            a_r <= phase == P_A ? {a_r[247:0], avm_readdata[7:0]} : a_r;
            byte_cnt <= in_last ? '0 : byte_cnt + 1'b1;
            if (in_last && phase != P_A)
                phase <= phase == P_N ? P_D : P_A;
        end else if (state == S_WAIT && i_core_finished) begin
            res_r <= i_core_result[247:0];
        end else if (state == S_PUT_DATA && done) begin
            res_r <= {res_r[239:0], 8'd0};
            byte_cnt <= out_last ? '0 : byte_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rsa_uart_master.sv
// tb_rsa_uart_master: UART slave and RSA core models around rsa_uart_master, with a tx byte scoreboard.
module tb_rsa_uart_master;
    logic i_clk = 0;
    logic i_rst_n = 0;
    logic [4:0] avm_address;
    logic avm_read, avm_write, o_core_start;
    logic [31:0] avm_readdata = 0;
    logic [31:0] avm_writedata;
    logic avm_waitrequest = 0;
    logic [255:0] o_core_a, o_core_d, o_core_n;
    logic [255:0] i_core_result = 0;
    logic i_core_finished = 0;

    rsa_uart_master dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_d(o_core_d), .o_core_n(o_core_n),
        .i_core_result(i_core_result), .i_core_finished(i_core_finished)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [255:0] a;
        logic [255:0] res;
    } blk_t;
    blk_t blks[5];
    localparam logic [255:0] N_KEY = 256'hCA35_0123456789ABCDEF_FEDCBA9876543210_13579BDF02468ACE_02468A0E_F831;
    localparam logic [255:0] D_KEY = 256'hB6AC_1122334455667788_99AABBCCDDEEFF00_0F1E2D3C4B5A6978_8796A5B4_6BD9;

    int tests = 0, fails = 0, viol = 0, starts = 0, stat_cnt = 0, tx_cnt = 0, lat = 0, core_lat = 6;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic stall_force = 1, rand_stall = 0, rand_gap = 0, trdy_off = 0, rrdy = 0;
    logic pend_rx = 0, pend_stat = 0, pend_wr = 0, prev_stall = 0, prev_rst = 0, prev_start = 0;
    logic [31:0] pend_wd = 0;
    logic [38:0] prev_req = 0, cur_req = 0;
    logic [255:0] st_a = 0, st_n = 0, st_d = 0, cur_res = 0;

    // UART slave and RSA core models: commit the transfer of the last rising edge, then drive the next cycle.
    always @(negedge i_clk) begin
        if (pend_rx) begin
            if (rx_q.size() == 0)
                viol++;
            else
                void'(rx_q.pop_front());
        end
        if (pend_stat)
            stat_cnt++;
        if (pend_wr) begin
            tx_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tx_byte: got %h, expected no write", pend_wd);
            end else begin
                exp_b = exp_q.pop_front();
                if (pend_wd !== {24'd0, exp_b}) begin
                    fails++;
                    $display("FAIL tx_byte: got %h, expected %h", pend_wd, {24'd0, exp_b});
                end
            end
        end
        cur_req = {avm_read, avm_write, avm_address, avm_writedata};
        if (i_rst_n && prev_rst && prev_stall && (prev_req[38] || prev_req[37]) && cur_req != prev_req)
            viol++;
        if (avm_read && avm_write)
            viol++;
        i_core_finished = 0;
        if (!i_rst_n) begin
            lat = 0;
        end else if (o_core_start) begin
            if (prev_start)
                viol++;
            starts++;
            st_a = o_core_a;
            st_n = o_core_n;
            st_d = o_core_d;
            lat = core_lat;
        end else if (lat > 0) begin
            lat--;
            if (lat == 0) begin
                i_core_finished = 1;
                i_core_result = cur_res;
                for (int k = 30; k >= 0; k--)
                    exp_q.push_back(cur_res[8*k +: 8]);
            end
        end
        prev_start = o_core_start && i_rst_n;
        avm_waitrequest = stall_force || (rand_stall && $urandom_range(0, 3) == 0);
        rrdy = rx_q.size() != 0 && (!rand_gap || $urandom_range(0, 2) != 0);
        avm_readdata = avm_address == 5'd8 ? {24'd0, rrdy, !trdy_off, 6'd0} :
                       (avm_address == 5'd0 && rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'hDEAD_BEEF;
        pend_rx = i_rst_n && avm_read && !avm_waitrequest && avm_address == 5'd0;
        pend_stat = i_rst_n && avm_read && !avm_waitrequest && avm_address == 5'd8;
        pend_wr = i_rst_n && avm_write && !avm_waitrequest && avm_address == 5'd4;
        pend_wd = avm_writedata;
        prev_req = cur_req;
        prev_stall = avm_waitrequest;
        prev_rst = i_rst_n;
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    task automatic send(input logic [255:0] v);
        for (int k = 31; k >= 0; k--)
            rx_q.push_back(v[8*k +: 8]);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_read"}, 256'(avm_read), 256'd1);
        check({tag, "_write"}, 256'(avm_write), 256'd0);
        check({tag, "_addr"}, 256'(avm_address), 256'd8);
        check({tag, "_wdata"}, 256'(avm_writedata), 256'd0);
        check({tag, "_start"}, 256'(o_core_start), 256'd0);
        check({tag, "_n"}, o_core_n, 256'd0);
        check({tag, "_d"}, o_core_d, 256'd0);
        check({tag, "_a"}, o_core_a, 256'd0);
    endtask

    task automatic wait_rx_empty();
        for (int c = 0; c < 5000 && rx_q.size() != 0; c++)
            tick();
        check("rx_drain", 256'(rx_q.size()), 256'd0);
        repeat (3) tick();
    endtask

    initial begin
        int base, tx_hold, sc;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 8; j++)
                blks[i].a[32*j +: 32] = $urandom();
            blks[i].res[255:248] = (i == 0) ? 8'h00 : 8'hA0 + 8'(i);
            for (int k = 0; k < 31; k++)
                blks[i].res[8*(30-k) +: 8] = 8'(31*i + k + 1);
        end
        #1;
        check_reset("rst0");
        tick();
        i_rst_n = 1;
        repeat (3) begin
            tick();
            check("stall_read", 256'(avm_read), 256'd1);
            check("stall_addr", 256'(avm_address), 256'd8);
        end
        check("stall_no_complete", 256'(stat_cnt), 256'd0);
        stall_force = 0;
        repeat (2) tick();
        check("stall_complete", 256'(stat_cnt), 256'd1);

        rand_stall = 1;
        rand_gap = 1;
        send(N_KEY);
        send(D_KEY);
        wait_rx_empty();
        check("key_n", o_core_n, N_KEY);
        check("key_d", o_core_d, D_KEY);
        check("key_no_start", 256'(starts), 256'd0);

        for (int i = 0; i < 5; i++) begin
            cur_res = blks[i].res;
            send(blks[i].a);
            for (int c = 0; c < 5000 && starts != i + 1; c++)
                tick();
            check("blk_start", 256'(starts), 256'(i + 1));
            check("blk_a", st_a, blks[i].a);
            check("blk_n", st_n, N_KEY);
            check("blk_d", st_d, D_KEY);
            if (i == 1) begin
                for (int c = 0; c < 5000 && tx_cnt < 31 + 10; c++)
                    tick();
                trdy_off = 1;
                repeat (3) tick();
                tx_hold = tx_cnt;
                sc = stat_cnt;
                repeat (50) tick();
                check("trdy_no_write", 256'(tx_cnt), 256'(tx_hold));
                check("trdy_polled", 256'(stat_cnt > sc), 256'd1);
                trdy_off = 0;
            end
            for (int c = 0; c < 5000 && !(tx_cnt == 31 * (i + 1) && exp_q.size() == 0); c++)
                tick();
            check("blk_tx_count", 256'(tx_cnt), 256'(31 * (i + 1)));
            check("blk_sb_empty", 256'(exp_q.size()), 256'd0);
        end

        core_lat = 30;
        send(blks[2].a);
        for (int c = 0; c < 5000 && starts != 6; c++)
            tick();
        check("wait_start", 256'(starts), 256'd6);
        repeat (3) tick();
        i_rst_n = 0;
        #1;
        check_reset("rst_wait");
        tick();
        i_rst_n = 1;
        send(~N_KEY);
        wait_rx_empty();
        check("reload_n", o_core_n, ~N_KEY);
        check("reload_d", o_core_d, 256'd0);

        core_lat = 6;
        cur_res = blks[0].res;
        base = tx_cnt;
        send(D_KEY);
        send(blks[3].a);
        for (int c = 0; c < 5000 && tx_cnt < base + 10; c++)
            tick();
        check("tx10_reached", 256'(tx_cnt), 256'(base + 10));
        i_rst_n = 0;
        #1;
        check_reset("rst_tx");
        tick();
        exp_q.delete();
        i_rst_n = 1;
        send(N_KEY);
        wait_rx_empty();
        check("after_tx_rst_n", o_core_n, N_KEY);
        check("after_tx_rst_d", o_core_d, 256'd0);
        check("protocol_violations", 256'(viol), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
